sprite_compositor: RTL and testbench
====================================

// Module: sprite_compositor
// PURPOSE
//  Parametrised per-pixel renderer between the game-logic blocks and the VGA timing block.
//  Composites N_OBJ rectangular objects (plane, lava, mountains, ...) with fixed priority.
//  Adds a score bar overlay, frame-latched positions (no tearing) and a game-over flash sequence.
//  Output colour is registered and valid LATENCY=2 clocks after the x/y/pix_en sample.
// PARAMETERS
//  N_OBJ        4          number of objects; index 0 = highest priority
//  COORD_W      10         width of x, y and object coordinates
//  SIZE_W       6          width of per-object width/height fields
//  BAR_H        8          score bar height in lines (rows 0..BAR_H-1)
//  BAR_SCALE    2          score bar pixels per score unit (power of two, shift)
//  BAR_RGB      24'hFFFF00 score bar colour
//  FLASH_RGB    24'hFF0000 game-over flash colour
//  FLASH_FRAMES 8          frames spent in FLASH before OVER (>=1)
// PORTS
//  clk          in   1              pixel clock
//  resetn       in   1              synchronous reset, active low
//  pix_en       in   1              display-active (bright) qualifier for current x/y
//  x            in   COORD_W        current pixel column
//  y            in   COORD_W        current pixel row
//  frame_start  in   1              one-cycle pulse at start of vertical blank
//  obj_en       in   N_OBJ          per-object enable
//  obj_col      in   N_OBJ          1 = column mode (extends to screen bottom), 0 = box
//  obj_x        in   N_OBJ*COORD_W  packed object left edges
//  obj_y        in   N_OBJ*COORD_W  packed object top edges
//  obj_w        in   N_OBJ*SIZE_W   packed object widths (inclusive extent)
//  obj_h        in   N_OBJ*SIZE_W   packed object heights (ignored in column mode)
//  obj_rgb      in   N_OBJ*24       packed colours {r,g,b}
//  game_over    in   1              level from game logic
//  score        in   8              current score
//  red/green/blue out 8 each        registered colour outputs
// BEHAVIOUR
//  Reset: red/green/blue=0, pipeline valid bits=0, state=PLAY, flash counter=0,
//   shadow obj_en=0 (nothing drawn until first frame_start), shadow score=0.
//  Shadowing: on frame_start, all obj_* and score copied to shadow regs; compares use shadows only.
//  Hit test i: x>=ox && x<=ox+ow; box: y>=oy && y<=oy+oh; column: y>=oy.
//   Sums computed at COORD_W+1 bits; no wrap (edge at 1023+w still compares correctly).
//  Bar hit: y<BAR_H && x < (score<<log2(BAR_SCALE)), at COORD_W+1 bits; score=0 -> no bar.
//  Stage 1 (reg): pix_en, bar hit, any-hit, winning index (lowest i with en&hit).
//  Stage 2 (reg): colour select by state:
//   PLAY : !pix_en->0; bar->BAR_RGB; hit->obj_rgb[idx]; else 0.
//   FLASH: !pix_en->0; bar->BAR_RGB; else FLASH_RGB if flash_cnt[0]==0, else 0.
//   OVER : !pix_en->0; bar->BAR_RGB; else 0.
//  FSM (updates only on frame_start, evaluated before shadow copy):
//   PLAY  -> FLASH if game_over; flash_cnt<=0.
//   FLASH -> PLAY if !game_over; else flash_cnt++; ->OVER when flash_cnt==FLASH_FRAMES-1.
//   OVER  -> PLAY if !game_over.
//  game_over changes between frame_start pulses have no effect until the next pulse.
//  frame_start and an active pixel on the same cycle: current pixel uses old shadows.
//  Reset mid-frame: outputs 0 on the next clock, pipeline flushed; no partial-frame artefacts retained.
// STRUCTURE
//  Package sprite_pkg: COORD_W/RGB_W constants, state enum {PLAY,FLASH,OVER}, pack/unpack index helpers.
//  Sub-module sprite_hit (one per object via generate): registered-input-free compare, box/column mode.
//  Top: shadow regs, priority encoder, FSM, 2-stage pipeline.
// TESTING
//  1 Obj0 box at (100,50) w=h=16 blue, pix_en=1, x=100,y=50 -> blue 2 clk later; x=117 -> black.
//  2 Obj0 and obj1 overlap at (120,60), colours blue/green -> blue (index 0 wins); disable obj0 -> green.
//  3 Obj2 column at x=300,y=400 w=30 -> green at (330,479), black at (331,479) and (300,399).
//  4 Move obj0 mid-frame without frame_start -> old position still drawn; after frame_start -> new.
//  5 score=10, BAR_SCALE=2 -> BAR_RGB at (19,0), not at (20,0) nor (0,8); score=0 -> no bar.
//  6 game_over=1 at frame_start -> 8 frames alternating red/black, then black+bar; game_over=0 -> PLAY.

Source files
------------

// File: rtl/sprite_compositor_pkg.sv
// Shared constants, FSM state type and small helpers for the sprite compositor.
package sprite_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned RGB_W   = 24;
  localparam int unsigned CH_W    = 8;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    FLASH = 2'd1,
    OVER  = 2'd2
  } state_e;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

  // Width of an object index; at least one bit even for a single object.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic rgb_t to_rgb(input logic [RGB_W-1:0] v);
    return rgb_t'(v);
  endfunction

endpackage

// File: rtl/sprite_compositor_hit.sv
// Combinational hit test of one pixel against one object (box or column mode).
module sprite_hit #(
  parameter int unsigned COORD_W = sprite_pkg::COORD_W,
  parameter int unsigned SIZE_W  = 6
) (
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic [COORD_W-1:0] i_ox,
  input  logic [COORD_W-1:0] i_oy,
  input  logic [SIZE_W-1:0]  i_ow,
  input  logic [SIZE_W-1:0]  i_oh,
  input  logic               i_col,
  output logic               o_hit_c
);

  localparam int unsigned EXT_W = COORD_W + 1;

  logic [EXT_W-1:0] w_x;
  logic [EXT_W-1:0] w_y;
  logic [EXT_W-1:0] w_left;
  logic [EXT_W-1:0] w_top;
  logic [EXT_W-1:0] w_right;
  logic [EXT_W-1:0] w_bottom;
  logic             w_in_x;
  logic             w_in_y;

  // Extra bit keeps edges beyond the screen from wrapping back to low coordinates.
  assign w_x      = EXT_W'(i_x);
  assign w_y      = EXT_W'(i_y);
  assign w_left   = EXT_W'(i_ox);
  assign w_top    = EXT_W'(i_oy);
  assign w_right  = w_left + EXT_W'(i_ow);
  assign w_bottom = w_top + EXT_W'(i_oh);

  assign w_in_x  = (w_x >= w_left) && (w_x <= w_right);
  assign w_in_y  = (w_y >= w_top) && (i_col || (w_y <= w_bottom));
  assign o_hit_c = w_in_x && w_in_y;

endmodule

// File: rtl/sprite_compositor.sv
// Per-pixel compositor: frame-latched objects, score bar, game-over flash, 2-clock pipeline.
module sprite_compositor #(
  parameter int unsigned N_OBJ        = 4,
  parameter int unsigned COORD_W      = sprite_pkg::COORD_W,
  parameter int unsigned SIZE_W       = 6,
  parameter int unsigned BAR_H        = 8,
  parameter int unsigned BAR_SCALE    = 2,
  parameter logic [23:0] BAR_RGB      = 24'hFFFF00,
  parameter logic [23:0] FLASH_RGB    = 24'hFF0000,
  parameter int unsigned FLASH_FRAMES = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      pix_en,
  input  logic [COORD_W-1:0]        x,
  input  logic [COORD_W-1:0]        y,
  input  logic                      frame_start,
  input  logic [N_OBJ-1:0]          obj_en,
  input  logic [N_OBJ-1:0]          obj_col,
  input  logic [N_OBJ*COORD_W-1:0]  obj_x,
  input  logic [N_OBJ*COORD_W-1:0]  obj_y,
  input  logic [N_OBJ*SIZE_W-1:0]   obj_w,
  input  logic [N_OBJ*SIZE_W-1:0]   obj_h,
  input  logic [N_OBJ*24-1:0]       obj_rgb,
  input  logic                      game_over,
  input  logic [7:0]                score,
  output logic [7:0]                red,
  output logic [7:0]                green,
  output logic [7:0]                blue
);

  import sprite_pkg::*;

  localparam int unsigned IDX_W     = idx_w(N_OBJ);
  localparam int unsigned EXT_W     = COORD_W + 1;
  localparam int unsigned BAR_SHIFT = $clog2(BAR_SCALE);
  localparam int unsigned FC_W      = $clog2(FLASH_FRAMES + 1);

  logic [N_OBJ-1:0]   r_en;
  logic [N_OBJ-1:0]   r_col;
  logic [COORD_W-1:0] r_ox  [N_OBJ];
  logic [COORD_W-1:0] r_oy  [N_OBJ];
  logic [SIZE_W-1:0]  r_ow  [N_OBJ];
  logic [SIZE_W-1:0]  r_oh  [N_OBJ];
  logic [RGB_W-1:0]   r_rgb [N_OBJ];
  logic [7:0]         r_score;

  state_e             r_state;
  logic [FC_W-1:0]    r_flash_cnt;

  logic               r_s1_pix;
  logic               r_s1_bar;
  logic               r_s1_hit;
  logic [IDX_W-1:0]   r_s1_idx;

  logic [N_OBJ-1:0]   w_raw_hit;
  logic [N_OBJ-1:0]   w_hit;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic [EXT_W-1:0]   w_bar_lim;
  logic               w_bar;
  rgb_t               w_rgb;

  // Object parameters only change at frame_start so a frame never tears.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_en    <= '0;
      r_col   <= '0;
      r_score <= '0;
      for (int i = 0; i < int'(N_OBJ); i++) begin
        r_ox[i]  <= '0;
        r_oy[i]  <= '0;
        r_ow[i]  <= '0;
        r_oh[i]  <= '0;
        r_rgb[i] <= '0;
      end
    end else if (frame_start) begin
      r_en    <= obj_en;
      r_col   <= obj_col;
      r_score <= score;
      for (int i = 0; i < int'(N_OBJ); i++) begin
        r_ox[i]  <= obj_x[i*COORD_W +: COORD_W];
        r_oy[i]  <= obj_y[i*COORD_W +: COORD_W];
        r_ow[i]  <= obj_w[i*SIZE_W +: SIZE_W];
        r_oh[i]  <= obj_h[i*SIZE_W +: SIZE_W];
        r_rgb[i] <= obj_rgb[i*RGB_W +: RGB_W];
      end
    end
  end

  for (genvar g = 0; g < int'(N_OBJ); g++) begin : g_hit
    sprite_hit #(
      .COORD_W (COORD_W),
      .SIZE_W  (SIZE_W)
    ) u_hit (
      .i_x     (x),
      .i_y     (y),
      .i_ox    (r_ox[g]),
      .i_oy    (r_oy[g]),
      .i_ow    (r_ow[g]),
      .i_oh    (r_oh[g]),
      .i_col   (r_col[g]),
      .o_hit_c (w_raw_hit[g])
    );
  end

  assign w_hit = w_raw_hit & r_en;
  assign w_any = |w_hit;

  // Lowest enabled index wins; scanning downwards leaves the lowest one last.
  always_comb begin
    w_idx = '0;
    for (int i = int'(N_OBJ) - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_idx = IDX_W'(i);
      end
    end
  end

  assign w_bar_lim = EXT_W'(r_score) << BAR_SHIFT;
  assign w_bar     = (EXT_W'(y) < EXT_W'(BAR_H)) && (EXT_W'(x) < w_bar_lim);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_s1_pix <= 1'b0;
      r_s1_bar <= 1'b0;
      r_s1_hit <= 1'b0;
      r_s1_idx <= '0;
    end else begin
      r_s1_pix <= pix_en;
      r_s1_bar <= w_bar;
      r_s1_hit <= w_any;
      r_s1_idx <= w_idx;
    end
  end

  // Game-over sequencing advances once per frame, before the shadow copy.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= PLAY;
      r_flash_cnt <= '0;
    end else if (frame_start) begin
      case (r_state)
        PLAY: begin
          if (game_over) begin
            r_state     <= FLASH;
            r_flash_cnt <= '0;
          end
        end
        FLASH: begin
          if (!game_over) begin
            r_state <= PLAY;
          end else begin
            r_flash_cnt <= r_flash_cnt + FC_W'(1);
            if (r_flash_cnt == FC_W'(FLASH_FRAMES - 1)) begin
              r_state <= OVER;
            end
          end
        end
        OVER: begin
          if (!game_over) begin
            r_state <= PLAY;
          end
        end
        default: r_state <= PLAY;
      endcase
    end
  end

  always_comb begin
    w_rgb = '0;
    if (r_s1_pix) begin
      if (r_s1_bar) begin
        w_rgb = to_rgb(BAR_RGB);
      end else begin
        case (r_state)
          PLAY:    if (r_s1_hit) w_rgb = to_rgb(r_rgb[r_s1_idx]);
          FLASH:   if (!r_flash_cnt[0]) w_rgb = to_rgb(FLASH_RGB);
          default: w_rgb = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else begin
      red   <= w_rgb.r;
      green <= w_rgb.g;
      blue  <= w_rgb.b;
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed-vector bench for sprite_compositor with a queue-based scoreboard.
module tb_sprite_compositor;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 10;
  localparam int unsigned SW = 6;

  localparam logic [23:0] BLUE  = 24'h0000FF;
  localparam logic [23:0] GREEN = 24'h00FF00;
  localparam logic [23:0] RED   = 24'hFF0000;
  localparam logic [23:0] BAR   = 24'hFFFF00;
  localparam logic [23:0] BLACK = 24'h000000;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              pix_en = 1'b0;
  logic [CW-1:0]     x = '0;
  logic [CW-1:0]     y = '0;
  logic              frame_start = 1'b0;
  logic [N-1:0]      obj_en = '0;
  logic [N-1:0]      obj_col = '0;
  logic [N*CW-1:0]   obj_x = '0;
  logic [N*CW-1:0]   obj_y = '0;
  logic [N*SW-1:0]   obj_w = '0;
  logic [N*SW-1:0]   obj_h = '0;
  logic [N*24-1:0]   obj_rgb = '0;
  logic              game_over = 1'b0;
  logic [7:0]        score = '0;
  logic [7:0]        red;
  logic [7:0]        green;
  logic [7:0]        blue;

  sprite_compositor dut (
    .clk         (clk),
    .resetn      (resetn),
    .pix_en      (pix_en),
    .x           (x),
    .y           (y),
    .frame_start (frame_start),
    .obj_en      (obj_en),
    .obj_col     (obj_col),
    .obj_x       (obj_x),
    .obj_y       (obj_y),
    .obj_w       (obj_w),
    .obj_h       (obj_h),
    .obj_rgb     (obj_rgb),
    .game_over   (game_over),
    .score       (score),
    .red         (red),
    .green       (green),
    .blue        (blue)
  );

  always #5 clk = ~clk;

  logic [23:0] exp_q [$];
  string       name_q [$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic        issue = 1'b0;
  logic        d1 = 1'b0;
  logic        d2 = 1'b0;
  logic [23:0] m_act;
  logic [23:0] m_exp;
  string       m_name;

  // Tags each issued pixel through the two-clock latency.
  always @(posedge clk) begin
    d1 <= issue;
    d2 <= d1;
  end

  always @(negedge clk) begin
    if (d2) begin
      m_act = {red, green, blue};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output got %h, nothing expected", m_act);
      end else begin
        m_exp  = exp_q.pop_front();
        m_name = name_q.pop_front();
        if (m_act !== m_exp) begin
          n_bad++;
          $display("FAIL %s got %h want %h", m_name, m_act, m_exp);
        end
      end
    end
  end

  task automatic pix(input int px, input int py, input logic pe, input logic fs,
                     input logic [23:0] e, input string nm);
    @(posedge clk); #1;
    x = CW'(px);
    y = CW'(py);
    pix_en = pe;
    frame_start = fs;
    issue = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      issue = 1'b0;
      pix_en = 1'b0;
      frame_start = 1'b0;
    end
  endtask

  task automatic frame();
    idle(2);
    @(posedge clk); #1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic set_obj(input int i, input logic en, input logic col, input int ox,
                         input int oy, input int ow, input int oh, input logic [23:0] c);
    obj_en[i]             = en;
    obj_col[i]            = col;
    obj_x[i*CW +: CW]     = CW'(ox);
    obj_y[i*CW +: CW]     = CW'(oy);
    obj_w[i*SW +: SW]     = SW'(ow);
    obj_h[i*SW +: SW]     = SW'(oh);
    obj_rgb[i*24 +: 24]   = c;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    idle(3);
    n_vec++;
    if ({red, green, blue} !== BLACK) begin
      n_bad++;
      $display("FAIL reset_rgb got %h want %h", {red, green, blue}, BLACK);
    end
    resetn = 1'b1;

    // Shadows empty until the first frame_start.
    set_obj(0, 1'b1, 1'b0, 100, 50, 16, 16, BLUE);
    pix(100, 50, 1'b1, 1'b0, BLACK, "pre_frame_shadow");
    frame();
    pix(100, 50, 1'b1, 1'b0, BLUE,  "box_topleft");
    pix(116, 66, 1'b1, 1'b0, BLUE,  "box_botright");
    pix(117, 50, 1'b1, 1'b0, BLACK, "box_right_out");
    pix(116, 67, 1'b1, 1'b0, BLACK, "box_bottom_out");
    pix(99,  50, 1'b1, 1'b0, BLACK, "box_left_out");
    pix(100, 50, 1'b0, 1'b0, BLACK, "pix_en_low");

    // Priority between overlapping boxes.
    set_obj(0, 1'b1, 1'b0, 110, 55, 16, 16, BLUE);
    set_obj(1, 1'b1, 1'b0, 120, 60, 16, 16, GREEN);
    frame();
    pix(120, 60, 1'b1, 1'b0, BLUE,  "overlap_idx0");
    pix(112, 56, 1'b1, 1'b0, BLUE,  "only_obj0");
    pix(130, 70, 1'b1, 1'b0, GREEN, "only_obj1");
    obj_en[0] = 1'b0;
    frame();
    pix(120, 60, 1'b1, 1'b0, GREEN, "overlap_obj0_off");

    // Column mode and right edge beyond the screen.
    set_obj(2, 1'b1, 1'b1, 300, 400, 30, 5, GREEN);
    set_obj(3, 1'b1, 1'b0, 1020, 500, 10, 4, 24'h123456);
    frame();
    pix(330, 479,  1'b1, 1'b0, GREEN, "col_right_edge");
    pix(331, 479,  1'b1, 1'b0, BLACK, "col_right_out");
    pix(300, 399,  1'b1, 1'b0, BLACK, "col_above");
    pix(315, 1023, 1'b1, 1'b0, GREEN, "col_bottom_row");
    pix(1023, 502, 1'b1, 1'b0, 24'h123456, "edge_no_wrap");
    pix(1023, 505, 1'b1, 1'b0, BLACK, "edge_box_below");

    // Moves only take effect at frame_start; a pixel on that cycle sees old shadows.
    set_obj(1, 1'b1, 1'b0, 200, 200, 16, 16, GREEN);
    pix(120, 60,  1'b1, 1'b0, GREEN, "move_old_pos");
    pix(200, 200, 1'b1, 1'b0, BLACK, "move_new_early");
    pix(120, 60,  1'b1, 1'b1, GREEN, "fs_same_cycle");
    pix(120, 60,  1'b1, 1'b0, BLACK, "move_old_gone");
    pix(200, 200, 1'b1, 1'b0, GREEN, "move_new_pos");

    // Score bar.
    score = 8'd10;
    frame();
    pix(19, 0, 1'b1, 1'b0, BAR,   "bar_last_px");
    pix(20, 0, 1'b1, 1'b0, BLACK, "bar_past_end");
    pix(0,  8, 1'b1, 1'b0, BLACK, "bar_below");
    pix(19, 7, 1'b1, 1'b0, BAR,   "bar_last_row");
    score = 8'd0;
    frame();
    pix(0, 0, 1'b1, 1'b0, BLACK, "bar_score0");

    // Game-over flash then OVER.
    score = 8'd10;
    game_over = 1'b1;
    frame();
    for (int i = 0; i < 8; i++) begin
      pix(200, 200, 1'b1, 1'b0, (i % 2 == 0) ? RED : BLACK, "flash_frame");
      pix(0, 0, 1'b1, 1'b0, BAR, "flash_bar");
      frame();
    end
    pix(200, 200, 1'b1, 1'b0, BLACK, "over_obj_hidden");
    pix(0,   0,   1'b1, 1'b0, BAR,   "over_bar");
    pix(0,   0,   1'b0, 1'b0, BLACK, "over_pix_en_low");
    game_over = 1'b0;
    pix(200, 200, 1'b1, 1'b0, BLACK, "over_until_frame");
    frame();
    pix(200, 200, 1'b1, 1'b0, GREEN, "back_to_play");

    // Abort from FLASH.
    game_over = 1'b1;
    frame();
    pix(200, 200, 1'b1, 1'b0, RED, "abort_flash");
    game_over = 1'b0;
    pix(200, 200, 1'b1, 1'b0, RED, "go_drop_midframe");
    frame();
    pix(200, 200, 1'b1, 1'b0, GREEN, "abort_to_play");

    // Reset mid-frame flushes the pipeline and the shadows.
    pix(200, 200, 1'b1, 1'b0, BLACK, "reset_flush");
    @(posedge clk); #1;
    issue = 1'b0;
    pix_en = 1'b0;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    pix(200, 200, 1'b1, 1'b0, BLACK, "post_reset_shadow");
    pix(0,   0,   1'b1, 1'b0, BLACK, "post_reset_bar");

    idle(4);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
